// File: rtl/leaky_integrator_pkg.sv
// Shared definitions for the leaky integrator: width derivation, output
// saturation limits and the clamp helper used by the top-level datapath.
package leaky_integrator_pkg;

  // Clamp result: saturated value plus a flag saying whether clamping happened.
  typedef struct packed {
    logic               clamped;
    logic signed [31:0] value;
  } sat_result_t;

  // Output/state width is the sample width plus guard bits.
  function automatic int ow_calc(input int bw, input int gw);
    return bw + gw;
  endfunction

  // Largest representable OW-bit signed value.
  function automatic logic signed [31:0] sat_max(input int ow);
    return (32'sd1 <<< (ow - 1)) - 32'sd1;
  endfunction

  // Smallest representable OW-bit signed value.
  function automatic logic signed [31:0] sat_min(input int ow);
    return -(32'sd1 <<< (ow - 1));
  endfunction

  // Clamp a wide (sign-extended OW+2 bit) sum into the OW-bit signed range.
  function automatic sat_result_t saturate(input logic signed [31:0] s, input int ow);
    sat_result_t r;
    if (s > sat_max(ow)) begin
      r.clamped = 1'b1;
      r.value   = sat_max(ow);
    end else if (s < sat_min(ow)) begin
      r.clamped = 1'b1;
      r.value   = sat_min(ow);
    end else begin
      r.clamped = 1'b0;
      r.value   = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/leaky_state_reg.sv
// Feedback state register for the leaky integrator: holds y and the
// one-cycle update strobe. Synchronous active-low RESET beats clear, and
// clear beats a load on the same cycle.
module leaky_state_reg #(
  parameter int W = 13
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                clear,
  input  logic                en,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] q,
  output logic                valid
);

  logic signed [W-1:0] q_r;
  logic                valid_r;

  // State and strobe update: reset, then clear, then load; strobe only on load.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      q_r     <= {W{1'b0}};
      valid_r <= 1'b0;
    end else if (clear) begin
      q_r     <= {W{1'b0}};
      valid_r <= 1'b0;
    end else if (en) begin
      q_r     <= d;
      valid_r <= 1'b1;
    end else begin
      q_r     <= q_r;
      valid_r <= 1'b0;
    end
  end

  assign q     = q_r;
  assign valid = valid_r;

endmodule

// File: rtl/leaky_integrator.sv
// Single-pole leaky integrator: y[n] = sat(y[n-1] + x[n] - (y[n-1] >>> k)).
// Optional build macro LEAKY_INTEGRATOR_ROUND_EN switches the leak term from
// a floor shift to a round-half-up shift for k>0; ports are identical.
// The leak/add/saturate path is combinational; y lives in leaky_state_reg.
module leaky_integrator
  import leaky_integrator_pkg::*;
#(
  parameter  int BW = 9,
  parameter  int GW = 4,
  parameter  int KW = 3,
  localparam int OW = ow_calc(BW, GW)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  input  logic signed [BW-1:0] in_data,
  input  logic        [KW-1:0] leak_k,
  input  logic                 clear,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data,
  output logic                 sat_flag
);

  // Two extra bits keep y + x - L free of internal overflow.
  localparam int SW = OW + 2;
  localparam logic signed [SW-1:0] ONE_S = {{(SW-1){1'b0}}, 1'b1};

  logic signed [SW-1:0] x_ext_s;
  logic signed [SW-1:0] y_ext_s;
  logic signed [SW-1:0] leak_s;
  logic signed [SW-1:0] sum_s;
  logic signed [31:0]   sum_wide_s;
  sat_result_t          sat_res_s;
  logic signed [OW-1:0] y_next_s;
  logic                 sat_flag_r;

  // Bring sample and current state to the common internal width.
  always_comb begin
    x_ext_s = {{(SW-BW){in_data[BW-1]}}, in_data};
    y_ext_s = {{(SW-OW){out_data[OW-1]}}, out_data};
  end

  // Leak term L derived from the current state and the sampled shift k.
  always_comb begin
    leak_s = y_ext_s;
`ifdef LEAKY_INTEGRATOR_ROUND_EN
    if (leak_k == {KW{1'b0}}) begin
      leak_s = y_ext_s;
    end else begin
      leak_s = (y_ext_s + (ONE_S <<< (leak_k - KW'(1'b1)))) >>> leak_k;
    end
`else
    leak_s = y_ext_s >>> leak_k;
`endif
  end

  // Accumulate, then clamp the wide sum into the output range.
  always_comb begin
    sum_s      = y_ext_s + x_ext_s - leak_s;
    sum_wide_s = {{(32-SW){sum_s[SW-1]}}, sum_s};
    sat_res_s  = saturate(sum_wide_s, OW);
    y_next_s   = OW'(sat_res_s.value);
  end

  leaky_state_reg #(
    .W(OW)
  ) u_state (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (clear),
    .en    (in_valid),
    .d     (y_next_s),
    .q     (out_data),
    .valid (out_valid)
  );

  // Sticky saturation flag: set by any clamped accepted sample, dropped by clear/reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sat_flag_r <= 1'b0;
    end else if (clear) begin
      sat_flag_r <= 1'b0;
    end else if (in_valid && sat_res_s.clamped) begin
      sat_flag_r <= 1'b1;
    end else begin
      sat_flag_r <= sat_flag_r;
    end
  end

  assign sat_flag = sat_flag_r;

endmodule
